rs232_tx: RTL and testbench
===========================

RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: number of i_clk cycles per serial bit; legal range 2..65535.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_start  input  1  transmit request; sampled on each rising edge.
REQ-005 i_data  input  8  byte to send; captured on the accepting edge only.
REQ-006 o_tx  output  1  serial line, idle high, 8N1 framing, LSB first.
REQ-007 o_busy  output  1  high while a frame is in progress.
REQ-008 o_finished  output  1  one-cycle pulse marking completion of a frame.

Function
REQ-009 FSM states are IDLE, START, DATA and STOP, with no other reachable state.
REQ-010 In IDLE, i_start=1 at edge k shall accept the request: i_data latched into the shift register, state to START, bit counter and baud counter cleared.
REQ-011 o_tx and o_busy shall be registered, so o_tx=0 and o_busy=1 are visible from edge k.
REQ-012 The baud counter shall count 0..CLKS_PER_BIT-1; each state or bit shall last exactly CLKS_PER_BIT cycles, with the transition occurring on the edge where the count equals CLKS_PER_BIT-1.
REQ-013 START shall drive o_tx=0 for one bit time, then the FSM moves to DATA.
REQ-014 DATA shall drive bits i_data[0] through i_data[7] in order, one bit time each, tracked by a 3-bit counter.
REQ-015 After bit 7 the FSM shall move to STOP.
REQ-016 STOP shall drive o_tx=1 for one bit time.
REQ-017 At the end of STOP (edge k+10*CLKS_PER_BIT) the FSM shall return to IDLE, with o_busy=0 and o_finished=1 for exactly that one cycle.
REQ-018 o_finished shall be 0 in every other cycle.
REQ-019 Frame length shall be exactly 10*CLKS_PER_BIT cycles from the accepting edge to the o_busy fall.
REQ-020 i_start while o_busy=1 shall be ignored: no queuing, no effect on the shift register, and no error flag.
REQ-021 i_data changes during a frame shall not affect the transmitted bits.
REQ-022 i_start=1 in the o_finished cycle (FSM already in IDLE) shall be accepted, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-023 i_start held high continuously shall produce back-to-back frames, each using the i_data present on its own accepting edge.
REQ-024 o_tx shall be glitch-free (driven directly by a flip-flop), and it shall be 1 in IDLE and STOP.

Reset
REQ-025 i_rst=1 at an edge shall force, from that edge, state=IDLE, o_tx=1, o_busy=0, o_finished=0, and all counters and the shift register to 0.
REQ-026 i_rst takes priority over i_start in the same cycle, so the request is dropped.
REQ-027 Reset mid-frame shall abort the frame immediately, without producing an o_finished pulse and without completing the stop bit.
REQ-028 The first i_start accepted after i_rst deasserts shall produce a complete, correct frame.

Verification (CLKS_PER_BIT=4, 40-cycle frame)
REQ-029 Single byte: i_start pulse with i_data=8'h23 -> o_tx holds 0,1,1,0,0,0,1,0,0,1 for 4 cycles each; o_busy is high for 40 cycles; o_finished pulses once at cycle 40.
REQ-030 Ignored start: send 8'hAB, then at cycle 12 drive i_start=1 with i_data=8'h5D -> the line still carries 0,1,1,0,1,0,1,0,1,1, and no second frame follows.
REQ-031 Back-to-back: i_start held high, i_data=8'h23 then changed to 8'h5D during frame 1 -> frame 2 starts on the o_finished cycle and carries 0,1,0,1,1,1,0,1,0,1 with no gap.
REQ-032 Reset mid-frame: i_rst=1 at cycle 18 of an 8'hAB frame -> from that edge o_tx=1, o_busy=0, and no o_finished pulse occurs.
REQ-033 Recovery after reset: the next i_start with 8'h00 -> start bit, eight 0 bits and a stop bit, 40 cycles total.
REQ-034 Start/reset collision: i_start=1 and i_rst=1 on the same edge -> no frame, and o_tx stays 1.
REQ-035 Bit timing check: a bench monitor checks every o_tx transition lands on a multiple of CLKS_PER_BIT from the accepting edge.
REQ-036 Parameter sweep: repeat REQ-029 with CLKS_PER_BIT=2 and CLKS_PER_BIT=16 -> frame lengths of 20 and 160 cycles respectively.

Source files
------------

// File: rtl/rs232_tx.sv
// RS-232 8N1 transmitter: one start bit, eight data bits LSB first, one stop bit,
// each lasting CLKS_PER_BIT clock cycles. All outputs come straight from flops.
module rs232_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_finished
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        r_finished;

  state_t      w_state_nxt;
  logic [15:0] w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_finished_nxt;
  logic        w_bit_done;

  assign w_bit_done = (r_baud == BAUD_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud + 16'd1;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_busy_nxt     = r_busy;
    w_finished_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (i_start) begin
          w_state_nxt = S_START;
          w_shift_nxt = i_data;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // Shift first so the next bit to send is always r_shift[0].
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_state_nxt    = S_IDLE;
          w_baud_nxt     = '0;
          w_tx_nxt       = 1'b1;
          w_busy_nxt     = 1'b0;
          w_finished_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_finished <= w_finished_nxt;
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_finished = r_finished;

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: three instances (CLKS_PER_BIT 4, 2, 16) checked every cycle
// against a frame-age model, plus directed frames with literal bit patterns.
module tb_rs232_tx;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] start;
  logic [7:0] data [3];
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] fin;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  rs232_tx #(.CLKS_PER_BIT(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_data(data[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_finished(fin[0])
  );
  rs232_tx #(.CLKS_PER_BIT(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_data(data[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_finished(fin[1])
  );
  rs232_tx #(.CLKS_PER_BIT(16)) u_dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_data(data[2]),
    .o_tx(tx[2]), .o_busy(busy[2]), .o_finished(fin[2])
  );

  // Line patterns, first transmitted bit in the MSB position.
  localparam logic [9:0] P23 = 10'b0110001001;
  localparam logic [9:0] PAB = 10'b0110101011;
  localparam logic [9:0] P5D = 10'b0101110101;
  localparam logic [9:0] P00 = 10'b0000000001;

  function automatic int cpb_of(int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just an accepted byte plus the number of edges since acceptance.
  bit       m_busy [3];
  bit       m_fin  [3];
  int       m_age  [3];
  logic [7:0] m_byte [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_busy[i] = 1'b0;
        m_fin[i]  = 1'b0;
        m_age[i]  = 0;
      end else if (m_busy[i]) begin
        m_fin[i] = 1'b0;
        m_age[i] = m_age[i] + 1;
        if (m_age[i] == 10 * cpb_of(i)) begin
          m_busy[i] = 1'b0;
          m_fin[i]  = 1'b1;
        end
      end else begin
        m_fin[i] = 1'b0;
        if (start[i]) begin
          m_busy[i] = 1'b1;
          m_age[i]  = 0;
          m_byte[i] = data[i];
        end
      end
    end
  end

  function automatic logic exp_tx(int i);
    int b;
    if (!m_busy[i]) return 1'b1;
    b = m_age[i] / cpb_of(i);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[i][b-1];
  endfunction

  // Per-cycle compare plus bit-boundary monitor measured from the DUT's own busy rise.
  logic [2:0] prev_tx   = 3'b111;
  logic [2:0] prev_busy = 3'b000;
  int         since [3];

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("tx[%0d]", i), tx[i], exp_tx(i));
        check($sformatf("busy[%0d]", i), busy[i], m_busy[i]);
        check($sformatf("finished[%0d]", i), fin[i], m_fin[i]);
        if (busy[i] && !prev_busy[i]) since[i] = 0;
        else since[i] = since[i] + 1;
        if (busy[i] && tx[i] !== prev_tx[i])
          check($sformatf("bit_edge[%0d]", i), since[i] % cpb_of(i), 0);
        prev_tx[i]   = tx[i];
        prev_busy[i] = busy[i];
      end
    end
  end

  task automatic send(int i, logic [7:0] d, bit hold);
    start[i] = 1'b1;
    data[i]  = d;
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
  endtask

  // Entered on the negedge just after the accepting edge; returns on the o_finished cycle.
  task automatic frame_check(int i, logic [9:0] pat, string name, int chg_at,
                             bit chg_start, logic [7:0] chg_data, bit chg_pulse);
    int         cpb = cpb_of(i);
    int         len = 0;
    logic [9:0] cap = '0;
    for (int t = 0; t < 10 * cpb + 4; t++) begin
      if (t == chg_at) begin
        start[i] = chg_start;
        data[i]  = chg_data;
      end else if (chg_pulse && chg_at >= 0 && t == chg_at + 1) begin
        start[i] = 1'b0;
      end
      if (!busy[i]) break;
      len++;
      if (t % cpb == cpb / 2) cap = {cap[8:0], tx[i]};
      @(negedge clk);
    end
    check({name, "_len"}, len, 10 * cpb);
    check({name, "_bits"}, cap, pat);
    check({name, "_fin"}, fin[i], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    rst   = 3'b111;
    start = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_tx[%0d]", i), tx[i], 1'b1);
      check($sformatf("reset_busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("reset_fin[%0d]", i), fin[i], 1'b0);
    end
    rst = 3'b000;
    @(negedge clk);

    // Single byte
    send(0, 8'h23, 1'b0);
    frame_check(0, P23, "single", -1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("single_fin_once", fin[0], 1'b0);
    repeat (3) @(negedge clk);

    // Start request during a frame is ignored
    send(0, 8'hAB, 1'b0);
    frame_check(0, PAB, "ignored", 12, 1'b1, 8'h5D, 1'b1);
    repeat (6) @(negedge clk);
    check("no_second_frame", busy[0], 1'b0);

    // Back-to-back with i_start held high
    send(0, 8'h23, 1'b1);
    frame_check(0, P23, "b2b_1", 5, 1'b1, 8'h5D, 1'b0);
    @(negedge clk);
    frame_check(0, P5D, "b2b_2", 0, 1'b0, 8'h5D, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-frame at edge 18 after acceptance
    send(0, 8'hAB, 1'b0);
    repeat (17) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_tx", tx[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    rst[0] = 1'b0;
    nf = 0;
    repeat (50) begin
      @(negedge clk);
      if (fin[0]) nf++;
    end
    check("abort_no_fin", nf, 0);

    // Recovery frame
    send(0, 8'h00, 1'b0);
    frame_check(0, P00, "recover", -1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // Start and reset on the same edge
    rst[0]   = 1'b1;
    start[0] = 1'b1;
    data[0]  = 8'hAB;
    @(negedge clk);
    check("collide_tx", tx[0], 1'b1);
    check("collide_busy", busy[0], 1'b0);
    rst[0]   = 1'b0;
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("collide_idle", busy[0], 1'b0);

    // Parameter sweep
    send(1, 8'h23, 1'b0);
    frame_check(1, P23, "cpb2", -1, 1'b0, 8'h00, 1'b0);
    send(2, 8'h23, 1'b0);
    frame_check(2, P23, "cpb16", -1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
